issue_queue_int: RTL and testbench

- Integer issue queue; sits directly upstream of the issue unit.
- Holds dispatched integer ops until both source operands are available, and snoops the CDB to wake waiting operands.
- Presents the oldest ready op to the issue unit via ready_int and the opcode/rsdata/rtdata/rdtag bus.
- Retires the presented entry when the issue unit returns issue_int.

---
 rtl/issue_pkg.sv | 20 ++
 rtl/iq_entry.sv | 59 +++++
 rtl/issue_queue_int.sv | 145 ++++++++++++++
 tb/tb_issue_queue_int.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_pkg.sv
// Shared widths and the storage record for one integer issue-queue slot.
package issue_pkg;

  localparam int OP_W   = 4;
  localparam int TAG_W  = 6;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   opcode;
    logic [DATA_W-1:0] rs_data;
    logic              rs_valid;
    logic [TAG_W-1:0]  rs_tag;
    logic [DATA_W-1:0] rt_data;
    logic              rt_valid;
    logic [TAG_W-1:0]  rt_tag;
    logic [TAG_W-1:0]  rd_tag;
  } iq_entry_t;

endpackage

// File: rtl/iq_entry.sv
// One issue-queue slot: picks its next contents (dispatch, upper neighbour or hold)
// and then lets a matching CDB broadcast fill in whichever operands are still waiting.
module iq_entry
  import issue_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              load_disp_i,
  input  logic              shift_i,
  input  iq_entry_t         disp_i,
  input  iq_entry_t         upper_i,
  input  logic              cdb_valid_i,
  input  logic [TAG_W-1:0]  cdb_tag_i,
  input  logic [DATA_W-1:0] cdb_data_i,
  output iq_entry_t         entry_o,
  output logic              ready_o
);

  iq_entry_t entry_q;
  iq_entry_t entry_d;
  iq_entry_t base;

  // Snoop is applied after the source mux so captures land in the slot's new position.
  always_comb begin
    base = entry_q;
    if (load_disp_i) begin
      base = disp_i;
    end else if (shift_i) begin
      base = upper_i;
    end

    entry_d = base;
    if (cdb_valid_i && base.valid && !base.rs_valid && (base.rs_tag == cdb_tag_i)) begin
      entry_d.rs_valid = 1'b1;
      entry_d.rs_data  = cdb_data_i;
    end
    if (cdb_valid_i && base.valid && !base.rt_valid && (base.rt_tag == cdb_tag_i)) begin
      entry_d.rt_valid = 1'b1;
      entry_d.rt_data  = cdb_data_i;
    end

    if (flush_i) begin
      entry_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign entry_o = entry_q;
  assign ready_o = entry_q.valid & entry_q.rs_valid & entry_q.rt_valid;

endmodule

// File: rtl/issue_queue_int.sv
// Compacting integer issue queue: oldest-first storage, lowest-index ready select,
// shift-down on grant, and CDB wake-up of waiting operands.
module issue_queue_int
  import issue_pkg::*;
#(
  parameter int DEPTH = 4
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              dispatch_en,
  input  logic [OP_W-1:0]   dispatch_opcode,
  input  logic [DATA_W-1:0] dispatch_rsdata,
  input  logic              dispatch_rsvalid,
  input  logic [TAG_W-1:0]  dispatch_rstag,
  input  logic [DATA_W-1:0] dispatch_rtdata,
  input  logic              dispatch_rtvalid,
  input  logic [TAG_W-1:0]  dispatch_rttag,
  input  logic [TAG_W-1:0]  dispatch_rdtag,
  output logic              queue_full,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tagout,
  input  logic [DATA_W-1:0] cdb_out,
  input  logic              issue_int,
  output logic              ready_int,
  output logic [OP_W-1:0]   opcode,
  output logic [DATA_W-1:0] rsdata,
  output logic [DATA_W-1:0] rtdata,
  output logic [TAG_W-1:0]  rdtag
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  iq_entry_t        entries [DEPTH];
  iq_entry_t        disp_entry;
  logic [DEPTH-1:0] ready_vec;
  logic [DEPTH-1:0] shift_vec;
  logic [DEPTH-1:0] load_vec;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] wr_idx;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_found;
  logic             grant;
  logic             accept;

  assign queue_full = (count_q == CNT_W'(DEPTH));
  assign grant      = issue_int & sel_found;
  assign accept     = dispatch_en & ~queue_full;
  // A same-cycle grant frees one slot below the tail, so the new op lands one lower.
  assign wr_idx     = grant ? (count_q - 1'b1) : count_q;

  always_comb begin
    disp_entry          = '0;
    disp_entry.valid    = 1'b1;
    disp_entry.opcode   = dispatch_opcode;
    disp_entry.rs_data  = dispatch_rsdata;
    disp_entry.rs_valid = dispatch_rsvalid;
    disp_entry.rs_tag   = dispatch_rstag;
    disp_entry.rt_data  = dispatch_rtdata;
    disp_entry.rt_valid = dispatch_rtvalid;
    disp_entry.rt_tag   = dispatch_rttag;
    disp_entry.rd_tag   = dispatch_rdtag;
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      iq_entry_t upper;

      if (gi == DEPTH - 1) begin : g_top
        assign upper = '0;
      end else begin : g_mid
        assign upper = entries[gi+1];
      end

      assign shift_vec[gi] = grant & (IDX_W'(gi) >= sel_idx);
      assign load_vec[gi]  = accept & (wr_idx == CNT_W'(gi));

      iq_entry u_entry (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (flush),
        .load_disp_i (load_vec[gi]),
        .shift_i     (shift_vec[gi]),
        .disp_i      (disp_entry),
        .upper_i     (upper),
        .cdb_valid_i (cdb_valid),
        .cdb_tag_i   (cdb_tagout),
        .cdb_data_i  (cdb_out),
        .entry_o     (entries[gi]),
        .ready_o     (ready_vec[gi])
      );
    end
  endgenerate

  // Oldest ready entry wins; index 0 is the oldest.
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready_vec[i] && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    ready_int = sel_found;
    opcode    = '0;
    rsdata    = '0;
    rtdata    = '0;
    rdtag     = '0;
    if (sel_found) begin
      opcode = entries[sel_idx].opcode;
      rsdata = entries[sel_idx].rs_data;
      rtdata = entries[sel_idx].rt_data;
      rdtag  = entries[sel_idx].rd_tag;
    end
  end

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (accept && !grant) begin
      count_d = count_q + 1'b1;
    end else if (grant && !accept) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_issue_queue_int.sv
// Randomised and directed bench for issue_queue_int against an in-order queue model.
module tb_issue_queue_int;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        dispatch_en;
  logic [3:0]  dispatch_opcode;
  logic [31:0] dispatch_rsdata;
  logic        dispatch_rsvalid;
  logic [5:0]  dispatch_rstag;
  logic [31:0] dispatch_rtdata;
  logic        dispatch_rtvalid;
  logic [5:0]  dispatch_rttag;
  logic [5:0]  dispatch_rdtag;
  logic        queue_full;
  logic        cdb_valid;
  logic [5:0]  cdb_tagout;
  logic [31:0] cdb_out;
  logic        issue_int;
  logic        ready_int;
  logic [3:0]  opcode;
  logic [31:0] rsdata;
  logic [31:0] rtdata;
  logic [5:0]  rdtag;

  issue_queue_int #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .dispatch_en(dispatch_en), .dispatch_opcode(dispatch_opcode),
    .dispatch_rsdata(dispatch_rsdata), .dispatch_rsvalid(dispatch_rsvalid),
    .dispatch_rstag(dispatch_rstag), .dispatch_rtdata(dispatch_rtdata),
    .dispatch_rtvalid(dispatch_rtvalid), .dispatch_rttag(dispatch_rttag),
    .dispatch_rdtag(dispatch_rdtag), .queue_full(queue_full),
    .cdb_valid(cdb_valid), .cdb_tagout(cdb_tagout), .cdb_out(cdb_out),
    .issue_int(issue_int), .ready_int(ready_int), .opcode(opcode),
    .rsdata(rsdata), .rtdata(rtdata), .rdtag(rdtag)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit [3:0]  op;
    bit [31:0] rs;
    bit        rsv;
    bit [5:0]  rst;
    bit [31:0] rt;
    bit        rtv;
    bit [5:0]  rtt;
    bit [5:0]  rd;
  } m_t;

  m_t q[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_sel();
    for (int i = 0; i < q.size(); i++)
      if (q[i].rsv && q[i].rtv) return i;
    return -1;
  endfunction

  function automatic m_t snoop(input m_t e);
    m_t r = e;
    if (cdb_valid && !r.rsv && r.rst == cdb_tagout) begin r.rsv = 1; r.rs = cdb_out; end
    if (cdb_valid && !r.rtv && r.rtt == cdb_tagout) begin r.rtv = 1; r.rt = cdb_out; end
    return r;
  endfunction

  task automatic model_step();
    int  sel;
    bit  acc;
    m_t  d;
    if (!reset || flush) begin
      q.delete();
      return;
    end
    sel = model_sel();
    acc = dispatch_en && (q.size() < DEPTH);
    for (int i = 0; i < q.size(); i++) q[i] = snoop(q[i]);
    if (issue_int && sel >= 0) q.delete(sel);
    if (acc) begin
      d.op = dispatch_opcode; d.rs = dispatch_rsdata; d.rsv = dispatch_rsvalid;
      d.rst = dispatch_rstag; d.rt = dispatch_rtdata; d.rtv = dispatch_rtvalid;
      d.rtt = dispatch_rttag; d.rd = dispatch_rdtag;
      q.push_back(snoop(d));
    end
  endtask

  // Per-cycle comparison of every output against the model's current contents.
  always @(negedge clk) begin : cmp
    int s;
    s = model_sel();
    check("cmp_ready", {31'd0, ready_int}, {31'd0, s >= 0});
    check("cmp_full", {31'd0, queue_full}, {31'd0, q.size() == DEPTH});
    check("cmp_opcode", {28'd0, opcode}, (s >= 0) ? {28'd0, q[s].op} : 32'd0);
    check("cmp_rsdata", rsdata, (s >= 0) ? q[s].rs : 32'd0);
    check("cmp_rtdata", rtdata, (s >= 0) ? q[s].rt : 32'd0);
    check("cmp_rdtag", {26'd0, rdtag}, (s >= 0) ? {26'd0, q[s].rd} : 32'd0);
  end

  task automatic idle();
    flush = 0; dispatch_en = 0; issue_int = 0; cdb_valid = 0;
    dispatch_opcode = 0; dispatch_rsdata = 0; dispatch_rsvalid = 0; dispatch_rstag = 0;
    dispatch_rtdata = 0; dispatch_rtvalid = 0; dispatch_rttag = 0; dispatch_rdtag = 0;
    cdb_tagout = 0; cdb_out = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    idle();
  endtask

  task automatic disp(input logic [3:0] op, input logic [31:0] rs, input logic rsv,
                      input logic [5:0] rst, input logic [31:0] rt, input logic rtv,
                      input logic [5:0] rtt, input logic [5:0] rd);
    dispatch_en = 1; dispatch_opcode = op; dispatch_rsdata = rs; dispatch_rsvalid = rsv;
    dispatch_rstag = rst; dispatch_rtdata = rt; dispatch_rtvalid = rtv;
    dispatch_rttag = rtt; dispatch_rdtag = rd;
  endtask

  task automatic cdb(input logic [5:0] tag, input logic [31:0] data);
    cdb_valid = 1; cdb_tagout = tag; cdb_out = data;
  endtask

  task automatic chk_out(input string name, input logic rdy, input logic [3:0] op,
                         input logic [31:0] rs, input logic [31:0] rt, input logic [5:0] rd);
    check({name, "_ready"}, {31'd0, ready_int}, {31'd0, rdy});
    check({name, "_opcode"}, {28'd0, opcode}, {28'd0, op});
    check({name, "_rsdata"}, rsdata, rs);
    check({name, "_rtdata"}, rtdata, rt);
    check({name, "_rdtag"}, {26'd0, rdtag}, {26'd0, rd});
  endtask

  initial begin
    reset = 0;
    idle();
    #2;
    chk_out("rst", 0, 0, 0, 0, 0);
    check("rst_full", {31'd0, queue_full}, 32'd0);
    tick(); tick();
    reset = 1;
    tick();

    // Single ready op presented, then granted.
    disp(4'h2, 5, 1, 0, 7, 1, 0, 6'h11);
    tick();
    chk_out("t1", 1, 4'h2, 5, 7, 6'h11);
    issue_int = 1;
    tick();
    chk_out("t1_empty", 0, 0, 0, 0, 0);

    // Younger ready op bypasses an older waiting one; CDB wakes the older one.
    disp(4'h3, 1, 1, 0, 0, 0, 6'h09, 6'h21);
    tick();
    disp(4'h4, 2, 1, 0, 3, 1, 0, 6'h22);
    tick();
    chk_out("t2_b", 1, 4'h4, 2, 3, 6'h22);
    cdb(6'h09, 32'hDEAD); issue_int = 1;
    tick();
    chk_out("t2_a", 1, 4'h3, 1, 32'hDEAD, 6'h21);
    issue_int = 1;
    tick();
    chk_out("t2_empty", 0, 0, 0, 0, 0);

    // Dispatch bypass of a same-cycle CDB broadcast.
    disp(4'h5, 0, 0, 6'h03, 9, 1, 0, 6'h05); cdb(6'h03, 32'h55);
    tick();
    chk_out("t3", 1, 4'h5, 32'h55, 9, 6'h05);
    issue_int = 1;
    tick();

    // Full queue: dispatch ignored even with a concurrent grant.
    for (int i = 1; i <= 4; i++) begin
      disp(4'(i), 32'(i), 1, 0, 32'(i), 1, 0, 6'(i));
      tick();
    end
    check("t4_full", {31'd0, queue_full}, 32'd1);
    disp(4'h5, 5, 1, 0, 5, 1, 0, 6'h05); issue_int = 1;
    tick();
    check("t4_notfull", {31'd0, queue_full}, 32'd0);
    chk_out("t4_next", 1, 4'h2, 2, 2, 6'h02);
    disp(4'h6, 6, 1, 0, 6, 1, 0, 6'h06);
    tick();
    check("t4_refull", {31'd0, queue_full}, 32'd1);
    begin
      logic [3:0] order [3];
      order[0] = 4'h3; order[1] = 4'h4; order[2] = 4'h6;
      for (int i = 0; i < 3; i++) begin
        issue_int = 1;
        tick();
        check("t4_order", {28'd0, opcode}, {28'd0, order[i]});
      end
    end
    issue_int = 1;
    tick();
    chk_out("t4_empty", 0, 0, 0, 0, 0);

    // Grant from the middle while dispatching.
    disp(4'h7, 0, 0, 6'h30, 70, 1, 0, 6'h07); tick();
    disp(4'h8, 80, 1, 0, 81, 1, 0, 6'h08); tick();
    disp(4'hA, 100, 1, 0, 0, 0, 6'h31, 6'h0A); tick();
    chk_out("t5_mid", 1, 4'h8, 80, 81, 6'h08);
    disp(4'h9, 90, 1, 0, 91, 1, 0, 6'h09); issue_int = 1;
    tick();
    chk_out("t5_new", 1, 4'h9, 90, 91, 6'h09);
    cdb(6'h30, 32'h3030);
    tick();
    chk_out("t5_e0", 1, 4'h7, 32'h3030, 70, 6'h07);
    issue_int = 1; cdb(6'h31, 32'h3131);
    tick();
    chk_out("t5_e2", 1, 4'hA, 100, 32'h3131, 6'h0A);
    issue_int = 1;
    tick();
    chk_out("t5_last", 1, 4'h9, 90, 91, 6'h09);
    issue_int = 1;
    tick();

    // Flush overrides dispatch and grant.
    for (int i = 1; i <= 3; i++) begin
      disp(4'(i), 1, 1, 0, 1, 1, 0, 6'(i));
      tick();
    end
    flush = 1; issue_int = 1; disp(4'hC, 1, 1, 0, 1, 1, 0, 6'h0C);
    tick();
    chk_out("t6_flush", 0, 0, 0, 0, 0);
    check("t6_full", {31'd0, queue_full}, 32'd0);
    tick();
    check("t6_after", {31'd0, ready_int}, 32'd0);

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      dispatch_en      = ($urandom_range(0, 99) < 60);
      dispatch_opcode  = 4'($urandom);
      dispatch_rsdata  = $urandom;
      dispatch_rsvalid = 1'($urandom_range(0, 1));
      dispatch_rstag   = 6'($urandom_range(0, 7));
      dispatch_rtdata  = $urandom;
      dispatch_rtvalid = 1'($urandom_range(0, 1));
      dispatch_rttag   = 6'($urandom_range(0, 7));
      dispatch_rdtag   = 6'($urandom);
      cdb_valid        = ($urandom_range(0, 99) < 50);
      cdb_tagout       = 6'($urandom_range(0, 7));
      cdb_out          = $urandom;
      issue_int        = ($urandom_range(0, 99) < 40);
      flush            = ($urandom_range(0, 99) < 2);
      tick();
    end

    // Asynchronous reset in the middle of a cycle clears outputs at once.
    disp(4'hE, 14, 1, 0, 15, 1, 0, 6'h0E);
    tick();
    check("t7_pre", {31'd0, ready_int}, 32'd1);
    #3;
    reset = 0;
    q.delete();
    #1;
    chk_out("t7_async", 0, 0, 0, 0, 0);
    check("t7_full", {31'd0, queue_full}, 32'd0);
    tick(); tick();
    reset = 1;
    tick();
    chk_out("t7_post", 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
